// File: rtl/aes_key_expand_seq_if.sv
// Handshake and key-bus bundle between the key-schedule source and its consumer.
//   start      : request a new expansion (master -> slave)
//   key        : 128-bit cipher key, FIPS-197 byte order (master -> slave)
//   busy       : expansion in progress (slave -> master)
//   done       : one-cycle pulse when the last round key lands (slave -> master)
//   keys_valid : all_keys stable and consistent (slave -> master)
//   all_keys   : packed round keys, slot i at [128*(i+1)-1 -: 128] (slave -> master)
interface aes_key_expand_seq_if #(
    parameter int unsigned NR = 10
);
    logic                      start;
    logic [127:0]              key;
    logic                      busy;
    logic                      done;
    logic                      keys_valid;
    logic [128*(NR+1)-1:0]     all_keys;

    modport master (
        output start, key,
        input  busy, done, keys_valid, all_keys
    );

    modport slave (
        input  start, key,
        output busy, done, keys_valid, all_keys
    );
endinterface

// File: rtl/aes_key_expand_seq.sv
// Sequential AES-128 key schedule: one round key per clock into a packed bus.
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   kx    : slave side of aes_key_expand_seq_if (start/key in; busy/done/keys_valid/all_keys out)
// A start in IDLE or DONE captures the key into slot 0; slots 1..NR follow on the next NR edges.
module aes_key_expand_seq #(
    parameter int unsigned NR = 10
) (
    input logic                 clk,
    input logic                 reset,
    aes_key_expand_seq_if.slave kx
);
    typedef enum logic [1:0] {StIdle, StExpand, StDone} state_e;

    state_e                state_q, state_d;
    logic [3:0]            rnd_q, rnd_d;
    logic [127:0]          prev_q, prev_d;
    logic [128*(NR+1)-1:0] keys_q, keys_d;
    logic                  done_q, done_d;
    logic                  kv_q, kv_d;

    logic [31:0]  t;
    logic [31:0]  w0, w1, w2, w3;
    logic [7:0]   rcon;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
               ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    always_comb begin
        unique case (rnd_q)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // RotWord is a byte rotate left of the last word of the previous round key.
    assign t  = sub_word({prev_q[23:0], prev_q[31:24]}) ^ {rcon, 24'h000000};
    assign w0 = prev_q[127:96] ^ t;
    assign w1 = prev_q[95:64]  ^ w0;
    assign w2 = prev_q[63:32]  ^ w1;
    assign w3 = prev_q[31:0]   ^ w2;

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        prev_d  = prev_q;
        keys_d  = keys_q;
        done_d  = 1'b0;
        kv_d    = kv_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (kx.start) begin
                    keys_d[127:0] = kx.key;
                    prev_d        = kx.key;
                    rnd_d         = 4'd1;
                    kv_d          = 1'b0;
                    state_d       = StExpand;
                end
            end
            StExpand: begin
                for (int unsigned i = 1; i <= NR; i++) begin
                    if (rnd_q == 4'(i)) keys_d[128*i +: 128] = {w0, w1, w2, w3};
                end
                prev_d = {w0, w1, w2, w3};
                if (rnd_q == 4'(NR)) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    kv_d    = 1'b1;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            rnd_q   <= 4'd0;
            prev_q  <= '0;
            keys_q  <= '0;
            done_q  <= 1'b0;
            kv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            prev_q  <= prev_d;
            keys_q  <= keys_d;
            done_q  <= done_d;
            kv_q    <= kv_d;
        end
    end

    assign kx.busy       = (state_q == StExpand);
    assign kx.done       = done_q;
    assign kx.keys_valid = kv_q;
    assign kx.all_keys   = keys_q;
endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Directed self-checking bench for aes_key_expand_seq, with an independent
// table-driven key-schedule and AES-128 encryption model.
module tb_aes_key_expand_seq;
    logic clk;
    logic reset;

    aes_key_expand_seq_if bus ();

    aes_key_expand_seq dut (
        .clk   (clk),
        .reset (reset),
        .kx    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;
    logic [7:0] sb_tab [256];

    localparam logic [127:0] KeyC1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KeyA  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p = 0; aa = a; bb = b;
        while (bb != 0) begin
            if (bb[0]) p ^= aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box by brute-force inverse search and the bitwise FIPS affine formula.
    task automatic build_sbox();
        logic [7:0] c;
        logic [7:0] inv;
        logic [7:0] o;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 0;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                o[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sb_tab[x] = o;
        end
    endtask

    function automatic logic [1407:0] ref_expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0] rc;
        logic [1407:0] r;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb_tab[tmp[31:24]], sb_tab[tmp[23:16]], sb_tab[tmp[15:8]],
                       sb_tab[tmp[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 11; i++) r[128*i +: 128] = {w[4*i], w[4*i+1], w[4*i+2], w[4*i+3]};
        return r;
    endfunction

    function automatic logic [127:0] ref_encrypt(input logic [1407:0] ks, input logic [127:0] pt);
        logic [7:0] s [16];
        logic [7:0] n [16];
        logic [127:0] st;
        st = pt ^ ks[127:0];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int i = 0; i < 16; i++) s[i] = sb_tab[st[127-8*i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) n[4*c+r] = s[4*((c+r)%4)+r];
            if (rd != 10) begin
                for (int c = 0; c < 4; c++) begin
                    s[4*c]   = xt(n[4*c]) ^ xt(n[4*c+1]) ^ n[4*c+1] ^ n[4*c+2] ^ n[4*c+3];
                    s[4*c+1] = n[4*c] ^ xt(n[4*c+1]) ^ xt(n[4*c+2]) ^ n[4*c+2] ^ n[4*c+3];
                    s[4*c+2] = n[4*c] ^ n[4*c+1] ^ xt(n[4*c+2]) ^ xt(n[4*c+3]) ^ n[4*c+3];
                    s[4*c+3] = xt(n[4*c]) ^ n[4*c] ^ n[4*c+1] ^ n[4*c+2] ^ xt(n[4*c+3]);
                end
                for (int i = 0; i < 16; i++) n[i] = s[i];
            end
            for (int i = 0; i < 16; i++) st[127-8*i -: 8] = n[i];
            st = st ^ ks[128*rd +: 128];
        end
        return st;
    endfunction

    function automatic logic [127:0] slot(input int i);
        return bus.all_keys[128*i +: 128];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until done, bounded so a stuck DUT still reaches the summary.
    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic check_all(input string tag, input logic [1407:0] exp);
        for (int i = 0; i < 11; i++)
            check($sformatf("%s slot%0d", tag, i), slot(i), exp[128*i +: 128]);
    endtask

    task automatic accept(input logic [127:0] k);
        bus.key   = k;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    int n;
    logic [1407:0] exp1, exp2;

    initial begin
        n_cmp = 0;
        n_err = 0;
        build_sbox();
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.key   = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst busy", 128'(bus.busy), 128'd0);
        check("rst done", 128'(bus.done), 128'd0);
        check("rst kv", 128'(bus.keys_valid), 128'd0);
        check_all("rst", '0);

        // FIPS-197 C.1 key
        accept(KeyC1);
        check("c1 slot0", slot(0), KeyC1);
        check("c1 busy", 128'(bus.busy), 128'd1);
        check("c1 kv low", 128'(bus.keys_valid), 128'd0);
        wait_done(n);
        check("c1 latency", 128'(n), 128'd10);
        check("c1 slot10", slot(10), 128'h13111d7fe3944a17f307a78b4d2b30c5);
        check("c1 kv", 128'(bus.keys_valid), 128'd1);
        check("c1 busy end", 128'(bus.busy), 128'd0);
        tick();
        check("c1 done fall", 128'(bus.done), 128'd0);
        check("c1 kv hold", 128'(bus.keys_valid), 128'd1);

        // Chain to an encryption model once keys are valid
        check("enc c1", ref_encrypt(bus.all_keys, 128'h00112233445566778899aabbccddeeff),
              128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        // Appendix A key, accepted from DONE
        accept(KeyA);
        check("a kv clear", 128'(bus.keys_valid), 128'd0);
        wait_done(n);
        check("a latency", 128'(n), 128'd10);
        check("a slot1", slot(1), 128'ha0fafe1788542cb123a339392a6c7605);
        check("a slot10", slot(10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check_all("a", ref_expand(KeyA));

        // start held high, key changes mid-expansion
        exp1 = ref_expand(KeyC1);
        exp2 = ref_expand(KeyA ^ KeyC1);
        bus.key   = KeyC1;
        bus.start = 1'b1;
        tick();
        for (int c = 1; c <= 10; c++) begin
            if (c == 5) bus.key = KeyA ^ KeyC1;
            tick();
            if (c == 6) check("hold slot0 kept", slot(0), KeyC1);
        end
        check("hold done1", 128'(bus.done), 128'd1);
        check_all("hold k1", exp1);
        tick();
        check("hold recap kv", 128'(bus.keys_valid), 128'd0);
        check("hold recap busy", 128'(bus.busy), 128'd1);
        check("hold recap slot0", slot(0), KeyA ^ KeyC1);
        check("hold old slot10", slot(10), exp1[1407 -: 128]);
        for (int c = 1; c < 10; c++) tick();
        check("hold pre done", 128'(bus.done), 128'd0);
        tick();
        bus.start = 1'b0;
        check("hold done2", 128'(bus.done), 128'd1);
        check_all("hold k2", exp2);

        // Reset mid-expansion at rnd=6
        accept(KeyA);
        for (int c = 1; c <= 5; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort busy", 128'(bus.busy), 128'd0);
        check("abort kv", 128'(bus.keys_valid), 128'd0);
        check("abort done", 128'(bus.done), 128'd0);
        check_all("abort", '0);
        tick();
        check("abort idle busy", 128'(bus.busy), 128'd0);
        accept(KeyC1);
        wait_done(n);
        check("post latency", 128'(n), 128'd10);
        check_all("post", exp1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/aes_key_expand_seq.md
# aes_key_expand_seq

Sequential AES-128 key schedule that generates the 11 round keys from one 128-bit cipher key, one round key per clock. It sits directly upstream of the encryption core and drives that core's packed `allKeys` bus, replacing a fully combinational expansion. A start/busy/done handshake brackets each expansion, and `keys_valid` tells the downstream core when the bus is stable.

## Interface
- `NR`, default 10: number of rounds; 11 round-key slots. Only 10 (AES-128) is supported.
- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `start` in 1: request a new expansion; sampled only in IDLE or DONE.
- `key` in 128: cipher key, FIPS-197 byte order; w0 = `key[127:96]`. Sampled on the accepting edge only.
- `busy` out 1: high while in EXPAND.
- `done` out 1: one-cycle pulse when the last round key is written.
- `keys_valid` out 1: high from `done` until the next accepted `start` or `reset`.
- `all_keys` out 1408: round key i occupies `all_keys[128*(i+1)-1 -: 128]` (i = 0..10).
  - Round key 0 is the cipher key in `[127:0]`.
  - Within a slot, `{w4i, w4i+1, w4i+2, w4i+3}`, with w4i in the MSBs.

## Operation
- States: IDLE, EXPAND, DONE. Round counter `rnd` is 4 bits, range 1..10.
- IDLE with `start`=1:
  - Write `key` to slot 0 and hold it as `prev`.
  - Set `rnd`=1, clear `keys_valid`, go to EXPAND.
- EXPAND, each cycle:
  - `t` = SubWord(RotWord(`prev[31:0]`)) XOR {Rcon[rnd], 24'h0}.
  - w0' = `prev[127:96]` XOR `t`.
  - w1' = `prev[95:64]` XOR w0'.
  - w2' = `prev[63:32]` XOR w1'.
  - w3' = `prev[31:0]` XOR w2'.
  - Write {w0',w1',w2',w3'} to slot `rnd` and to `prev`, then increment `rnd`.
- SubWord uses 4 instances of the codebase S-box, purely combinational.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36 (byte, placed in the MSB byte of the word).
- When slot 10 is written: go to DONE, pulse `done`, set `keys_valid`.
- DONE with `start`=1: identical to IDLE acceptance, so back-to-back expansions are allowed.
- `start` while in EXPAND is ignored. No queuing; `key` changes during EXPAND have no effect.
- Slots not yet rewritten keep their old contents during EXPAND. They are not guaranteed consistent until `keys_valid`=1.
- All arithmetic is bitwise XOR; there are no carries.

## Timing
- Reset values:
  - State IDLE, `rnd`=0.
  - `busy`=0, `done`=0, `keys_valid`=0.
  - `all_keys`=0, `prev`=0.
- Reset has priority over all other activity. Reset during EXPAND aborts it; the cycle after reset deasserts, outputs equal their reset values.
- `start` accepted at edge N:
  - Slot 0 is valid after edge N.
  - `busy`=1 from edge N through edge N+10.
  - Slot i is written at edge N+i.
- `done` and `keys_valid` rise at edge N+10. `done` falls at edge N+11.
- Latency from start to valid keys: 10 cycles after the accepting edge. Throughput is one expansion per 11 cycles.
- A `start` accepted in DONE clears `keys_valid` at that same edge.

## Test plan
- FIPS-197 C.1 key, `key`=000102030405060708090a0b0c0d0e0f, `start` pulse:
  - `done` pulse exactly 10 edges after acceptance.
  - Slot 10 = 13111d7fe3944a17f307a78b4d2b30c5.
  - Slot 0 = `key`.
- Appendix A key, `key`=2b7e151628aed2a6abf7158809cf4f3c:
  - Slot 1 = a0fafe1788542cb123a339392a6c7605.
  - Slot 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Check all 11 slots against a reference model.
- `start` held high continuously with a key change at cycle 5:
  - Second-key capture happens only at the DONE cycle.
  - First result completes uncorrupted.
  - `keys_valid` drops at recapture, and the second key's results appear 10 edges later.
- Reset asserted at `rnd`=6 mid-EXPAND:
  - Next cycle `all_keys`=0, `busy`=0, `keys_valid`=0.
  - A subsequent `start` produces correct keys.
- Chain to the encryption core, with key 000102…0f and data 00112233445566778899aabbccddeeff:
  - Release the core from reset after `keys_valid`.
  - Final state = 69c4e0d86a7b0430d8cdb78070b4c55a.
